gift64_round_stage: RTL
=======================

Name: gift64_round_stage

Overview:
- One registered GIFT-64 round for the pipelined datapath. Each stage applies SubCells (16 nibble S-boxes), PermBits, AddRoundKey and the round constant.
- In parallel it computes the next round key and the next round constant, then forwards the tuple {state, key, rc} to the next stage.
- 28 instances are chained to form the full cipher. Stages communicate over valid/ready handshakes, with a 2-entry skid buffer for full throughput and registered backpressure.

Parameters:
- STATE_W, 64, cipher state width (fixed for GIFT-64; any other value is a lint error).
- KEY_W, 128, key width.
- RC_W, 6, round-constant width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream tuple valid.
- in_ready  out  1  stage can accept; driven directly from a register.
- in_state  in  64  state before this round.
- in_key  in  128  round key; words k7..k0, with k0 = bits 15:0.
- in_rc  in  6  round constant for this round, c5..c0.
- out_valid  out  1  output tuple valid.
- out_ready  in  1  downstream accept.
- out_state  out  64  state after this round.
- out_key  out  128  updated key for the next round.
- out_rc  out  6  next round constant.

Behaviour:
- Reset (asynchronous, rst_n low): out_valid=0, in_ready=1, out_state/out_key/out_rc=0, skid buffer empty.
- Transfers: a beat transfers when valid and ready are both high on a rising clk edge. Data is computed combinationally from the in_* inputs and captured on the accepting edge, so latency is 1 cycle.
- SubCells: nibble i (bits 4i+3:4i) is mapped through the GIFT S-box, table 0..F -> 1,A,4,C,6,F,3,9,2,D,B,7,5,0,8,E.
- PermBits: bit i moves to position P(i) = 4*(i/16) + 16*((3*((i%16)/4) + (i%4)) % 4) + (i%4).
- AddRoundKey:
  - U = in_key[31:16], V = in_key[15:0].
  - For i = 0..15: bit 4i+1 ^= U[i]; bit 4i ^= V[i].
- Round constant:
  - c5..c0 are XORed into bits 23, 19, 15, 11, 7, 3 respectively.
  - Bit 63 ^= 1.
- Key update: out_key = {in_key[31:16] rotated right by 2, in_key[15:0] rotated right by 12, in_key[127:32]}.
- RC update: out_rc = {c4, c3, c2, c1, c0, c5^c4^1}. This is computed from in_rc, so the first stage is fed rc=6'h01.
- Skid buffer (two registers: main and skid):
  - in_ready = !skid_full, registered.
  - Main empty, or main drained this cycle (out_ready high): the input beat goes to main.
  - Main full and not drained: the input beat goes to skid and skid_full is set.
  - When main drains and skid is full, skid moves to main the same edge and skid_full clears.
  - Sustained throughput is 1 beat/cycle when out_ready stays high.
- Ordering: beats leave strictly in acceptance order, and none are dropped or duplicated.
- Output stability: out_* values are held stable while out_valid=1 and out_ready=0.
- Boundary conditions:
  - Both registers full: in_ready=0 and in_valid is ignored.
  - Accept and drain in the same cycle while full: skid moves to main, the new beat is not accepted (in_ready was 0), and in_ready rises next cycle.
  - in_valid high while in_ready low: no state change.
  - Reset asserted mid-stream: all buffered beats are discarded immediately (asynchronous). out_valid drops with no clock edge required.
  - Reset release: the first accept can occur on the first clk edge after rst_n rises.
- Payload registers: no reset is required functionally, but they are reset to 0 for deterministic simulation.

Decomposition:
- Shared package/header holds:
  - GIFT S-box table.
  - P64 permutation function.
  - Round-constant bit positions {23,19,15,11,7,3,63}.
  - RC_INIT = 6'h01.
  - Width constants.
- One natural sub-module, gift64_round_fn: purely combinational {state, key, rc} -> {state', key', rc'}. It instantiates 16 nibble S-boxes.
- gift64_round_stage wraps gift64_round_fn with the handshake and skid logic.

Test Plan:
- Zero vector: in_state=0, in_key=0, in_rc=6'h01, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_state=64'h9111111111111119, out_key=0, out_rc=6'h03.
- Key injection: in_state=0, in_key=128'h0000...FFFF (k0=FFFF only), in_rc=6'h01 -> out_state=64'h8000000000000008, out_key=128'h0000FFFF000000000000000000000000.
- Backpressure: hold out_ready=0 and send 3 beats ->
  - First two beats accepted.
  - in_ready=0 from the cycle after the second accept.
  - Raising out_ready drains both beats in order on consecutive cycles, then in_ready=1.
- Throughput: 28 chained stages, P=0, K=0, rc=01, out_ready constantly 1 -> ciphertext 64'hF62BC3EF34F775AC appears 28 cycles after input. Back-to-back inputs each produce one result per cycle.
- Reset mid-operation: with both buffers full, pulse rst_n low between clock edges -> out_valid=0 and in_ready=1 immediately. Prior beats never appear after release.
- Random stall: random in_valid/out_ready over 10k beats, compared against a reference model -> no loss, duplication or reorder, and out_* stable while stalled.

Source files
------------

// File: rtl/gift64_round_stage_pkg.sv
// Shared GIFT-64 constants: widths, S-box, bit permutation and round-constant placement.
package gift64_round_stage_pkg;

    localparam int GIFT_STATE_W = 64;
    localparam int GIFT_KEY_W   = 128;
    localparam int GIFT_RC_W    = 6;

    // Round constant fed to the first stage of the chain
    localparam logic [GIFT_RC_W-1:0] RC_INIT = 6'h01;

    // S-box table packed so that nibble n holds S(n)
    localparam logic [63:0] SBOX_TABLE = 64'hE8057BD293F6C4A1;

    // State bit positions receiving c5..c0, plus the fixed bit set every round
    localparam int RC_POS_C5  = 23;
    localparam int RC_POS_C4  = 19;
    localparam int RC_POS_C3  = 15;
    localparam int RC_POS_C2  = 11;
    localparam int RC_POS_C1  = 7;
    localparam int RC_POS_C0  = 3;
    localparam int RC_POS_MSB = 63;

    function automatic logic [3:0] gift_sbox(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

    // Destination of state bit i under PermBits
    function automatic int gift_p64(input int i);
        return 4 * (i / 16) + 16 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
    endfunction

    // XOR mask carrying the round constant and the fixed top bit
    function automatic logic [GIFT_STATE_W-1:0] gift_rc_mask(input logic [GIFT_RC_W-1:0] rc);
        logic [GIFT_STATE_W-1:0] m;
        m = '0;
        m[RC_POS_C5]  = rc[5];
        m[RC_POS_C4]  = rc[4];
        m[RC_POS_C3]  = rc[3];
        m[RC_POS_C2]  = rc[2];
        m[RC_POS_C1]  = rc[1];
        m[RC_POS_C0]  = rc[0];
        m[RC_POS_MSB] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/gift64_round_fn.sv
// Purely combinational GIFT-64 round: SubCells, PermBits, AddRoundKey, round
// constant, plus the key-schedule and round-constant updates for the next round.
module gift64_round_fn
    import gift64_round_stage_pkg::*;
(
    input  logic [GIFT_STATE_W-1:0] state,
    input  logic [GIFT_KEY_W-1:0]   key,
    input  logic [GIFT_RC_W-1:0]    rc,
    output logic [GIFT_STATE_W-1:0] nxt_state,
    output logic [GIFT_KEY_W-1:0]   nxt_key,
    output logic [GIFT_RC_W-1:0]    nxt_rc
);

    logic [GIFT_STATE_W-1:0] sub_s;
    logic [GIFT_STATE_W-1:0] perm_s;
    logic [GIFT_STATE_W-1:0] ark_s;
    logic [15:0]             u_w;
    logic [15:0]             v_w;

    // Round key words: U = k1, V = k0
    assign u_w = key[31:16];
    assign v_w = key[15:0];

    for (genvar n = 0; n < 16; n++) begin : g_sbox
        assign sub_s[4*n +: 4] = gift_sbox(state[4*n +: 4]);
    end

    for (genvar n = 0; n < GIFT_STATE_W; n++) begin : g_perm
        assign perm_s[gift_p64(n)] = sub_s[n];
    end

    // U lands on bit 1 and V on bit 0 of every nibble
    for (genvar n = 0; n < 16; n++) begin : g_ark
        assign ark_s[4*n +: 4] = perm_s[4*n +: 4] ^ {2'b00, u_w[n], v_w[n]};
    end

    assign nxt_state = ark_s ^ gift_rc_mask(rc);

    // Key schedule: rotate k1 right by 2 and k0 right by 12, then shift whole key down two words
    assign nxt_key = {u_w[1:0], u_w[15:2], v_w[11:0], v_w[15:12], key[GIFT_KEY_W-1:32]};

    // 6-bit LFSR step
    assign nxt_rc = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};

endmodule

// File: rtl/gift64_round_stage.sv
// One registered GIFT-64 round with a valid/ready handshake and a 2-entry skid
// buffer, so in_ready comes straight from a flop while throughput stays 1 beat/cycle.
module gift64_round_stage
    import gift64_round_stage_pkg::*;
#(
    // Only 64 is meaningful; other widths mismatch the round function ports
    parameter int STATE_W = GIFT_STATE_W,
    parameter int KEY_W   = GIFT_KEY_W,
    parameter int RC_W    = GIFT_RC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic [KEY_W-1:0]   in_key,
    input  logic [RC_W-1:0]    in_rc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic [KEY_W-1:0]   out_key,
    output logic [RC_W-1:0]    out_rc
);

    // ---- stage p0: combinational round on the incoming tuple ----
    logic [STATE_W-1:0] state_p0;
    logic [KEY_W-1:0]   key_p0;
    logic [RC_W-1:0]    rc_p0;

    gift64_round_fn u_round (
        .state     (in_state),
        .key       (in_key),
        .rc        (in_rc),
        .nxt_state (state_p0),
        .nxt_key   (key_p0),
        .nxt_rc    (rc_p0)
    );

    // ---- stage p1: main output register and skid register ----
    logic               vld_p1;
    logic               skid_vld_p1;
    logic               rdy_p1;
    logic [STATE_W-1:0] state_p1;
    logic [KEY_W-1:0]   key_p1;
    logic [RC_W-1:0]    rc_p1;
    logic [STATE_W-1:0] skid_state_p1;
    logic [KEY_W-1:0]   skid_key_p1;
    logic [RC_W-1:0]    skid_rc_p1;

    logic accept;
    logic drain;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;
    logic vld_nxt;
    logic skid_vld_nxt;

    // Decide where an accepted beat goes and what the buffer occupancy becomes
    always_comb begin
        accept         = in_valid & rdy_p1;
        drain          = vld_p1 & out_ready;
        load_main_skid = drain & skid_vld_p1;
        load_main_in   = accept & ~skid_vld_p1 & (~vld_p1 | drain);
        load_skid      = accept & vld_p1 & ~drain;
        vld_nxt        = load_main_skid | load_main_in | (vld_p1 & ~drain);
        skid_vld_nxt   = load_skid | (skid_vld_p1 & ~drain);
    end

    // Occupancy flags; in_ready is precomputed so it leaves the block from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_p1      <= 1'b1;
        end else begin
            vld_p1      <= vld_nxt;
            skid_vld_p1 <= skid_vld_nxt;
            rdy_p1      <= ~skid_vld_nxt;
        end
    end

    // Payload registers; cleared on reset only for deterministic simulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1      <= '0;
            key_p1        <= '0;
            rc_p1         <= '0;
            skid_state_p1 <= '0;
            skid_key_p1   <= '0;
            skid_rc_p1    <= '0;
        end else begin
            if (load_main_skid) begin
                state_p1 <= skid_state_p1;
                key_p1   <= skid_key_p1;
                rc_p1    <= skid_rc_p1;
            end else if (load_main_in) begin
                state_p1 <= state_p0;
                key_p1   <= key_p0;
                rc_p1    <= rc_p0;
            end
            if (load_skid) begin
                skid_state_p1 <= state_p0;
                skid_key_p1   <= key_p0;
                skid_rc_p1    <= rc_p0;
            end
        end
    end

    assign in_ready  = rdy_p1;
    assign out_valid = vld_p1;
    assign out_state = state_p1;
    assign out_key   = key_p1;
    assign out_rc    = rc_p1;

endmodule
